// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   ID-stage main control for the 5-stage MIPS pipeline.
//   - Decodes the ID opcode into an 11-bit control word (outDecode).
//   - Registers {control, rt} into the ID/EX latch.
//   - Detects load-use hazards, holds PC and IF/ID for LOAD_USE_STALL cycles
//     and inserts bubbles while holding.
//   - Flush kills the ID instruction and aborts any stall.
//   - Sticky outIllegal once an undefined opcode is issued into EX.
//
// Control word: [10] Jump, [9] BranchNE, [8:5] RegDst/ALUOp1/ALUOp0/ALUSrc,
//               [4:2] Branch/MemRead/MemWrite, [1:0] RegWrite/MemtoReg
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst            synchronous active-low reset
//   inInstruction  instruction in IF/ID
//   inFlush        redirect from a later stage, kills the ID instruction
//   outDecode      combinational control word of inInstruction
//   outControl     registered ID/EX control word
//   outExRt        registered rt of the instruction in EX
//   outPcWrite     PC load enable
//   outIfIdWrite   IF/ID load enable
//   outStall       high while a hazard bubble is being inserted
//   outIllegal     sticky illegal-opcode flag
//
// State | meaning
// ------+-----------------------------------------------------------
// RUN   | normal issue; a detected hazard costs its first bubble here
// STALL | extra hazard bubbles, cnt counts the remaining ones down to 0

module pipelined_control_unit #(
    parameter int INST_W         = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_W-1:0]     inInstruction,
    input  logic                  inFlush,
    output logic [10:0]           outDecode,
    output logic [10:0]           outControl,
    output logic [REG_ADDR_W-1:0] outExRt,
    output logic                  outPcWrite,
    output logic                  outIfIdWrite,
    output logic                  outStall,
    output logic                  outIllegal
);

    if (LOAD_USE_STALL < 1 || LOAD_USE_STALL > 3) begin : g_bad_stall
        $error("pipelined_control_unit: LOAD_USE_STALL must be in 1..3");
    end

    localparam int RS_LSB = INST_W - 6 - REG_ADDR_W;
    localparam int RT_LSB = RS_LSB - REG_ADDR_W;

    // First hazard cycle is spent in RUN, so STALL covers the remaining ones.
    localparam logic [1:0] CNT_INIT = 2'((LOAD_USE_STALL > 1) ? (LOAD_USE_STALL - 2) : 0);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  illegal_id;
    logic                  uses_rt;
    logic                  hazard;

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            cnt;
    logic [1:0]            cnt_nxt;
    logic [10:0]           ctrl_nxt;
    logic [REG_ADDR_W-1:0] rt_nxt;
    logic                  ill_nxt;

    logic                  unused_low_bits;

    assign opcode = inInstruction[INST_W-1 -: 6];
    assign rs     = inInstruction[RS_LSB +: REG_ADDR_W];
    assign rt     = inInstruction[RT_LSB +: REG_ADDR_W];

    // Immediate/shamt/funct fields do not affect main control.
    assign unused_low_bits = ^inInstruction[RT_LSB-1:0];

    always_comb begin
        outDecode  = 11'h000;
        illegal_id = 1'b0;
        case (opcode)
            6'd0:                outDecode = 11'h182;
            6'd35:               outDecode = 11'h02B;
            6'd43:               outDecode = 11'h024;
            6'd4:                outDecode = 11'h050;
            6'd5:                outDecode = 11'h250;
            6'd8:                outDecode = 11'h022;
            6'd12, 6'd13, 6'd10: outDecode = 11'h0E2;
            6'd2:                outDecode = 11'h400;
            default:             illegal_id = 1'b1;
        endcase
    end

    assign uses_rt = (opcode == 6'd0) || (opcode == 6'd4) ||
                     (opcode == 6'd5) || (opcode == 6'd43);

    // outControl[3] is MemRead of the instruction in EX; $0 never creates a hazard.
    assign hazard = outControl[3] && (outExRt != '0) &&
                    ((rs == outExRt) || (uses_rt && (rt == outExRt)));

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ctrl_nxt     = 11'h000;
        rt_nxt       = '0;
        ill_nxt      = outIllegal;
        outPcWrite   = 1'b1;
        outIfIdWrite = 1'b1;
        outStall     = 1'b0;
        if (!rst) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
            ill_nxt   = 1'b0;
        end else if (inFlush) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        outPcWrite   = 1'b0;
                        outIfIdWrite = 1'b0;
                        outStall     = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = CNT_INIT;
                        end
                    end else begin
                        ctrl_nxt = outDecode;
                        rt_nxt   = rt;
                        if (illegal_id) begin
                            ill_nxt = 1'b1;
                        end
                    end
                end
                STALL: begin
                    outPcWrite   = 1'b0;
                    outIfIdWrite = 1'b0;
                    outStall     = 1'b1;
                    if (cnt == 2'd0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - 2'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            cnt        <= 2'd0;
            outControl <= 11'h000;
            outExRt    <= '0;
            outIllegal <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            outControl <= ctrl_nxt;
            outExRt    <= rt_nxt;
            outIllegal <= ill_nxt;
        end
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation MIPS main control for the 5-stage pipeline.
- Decodes the ID-stage opcode into an extended 11-bit control word and registers it into the ID/EX control latch together with rt.
- Detects load-use hazards and stalls PC and IF/ID for a parametrised number of cycles; inserts bubbles on stall or flush.
- Flags illegal opcodes with a sticky error bit.

Parameters:
- INST_W, 32: instruction width; opcode is bits [INST_W-1:INST_W-6].
- REG_ADDR_W, 5: register specifier width; rs = bits [25:21], rt = bits [20:16] for INST_W=32.
- LOAD_USE_STALL, 1: stall cycles per load-use hazard. Legal range 1..3; elaboration error outside it.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- inInstruction  in  INST_W  instruction currently in IF/ID
- inFlush  in  1  branch/jump redirect from a later stage; kill the ID instruction
- outDecode  out  11  combinational control word of inInstruction (ID-stage jump resolution)
- outControl  out  11  registered ID/EX control word
- outExRt  out  REG_ADDR_W  registered rt of the instruction in EX
- outPcWrite  out  1  PC load enable
- outIfIdWrite  out  1  IF/ID load enable
- outStall  out  1  high while a bubble is being inserted for a hazard
- outIllegal  out  1  sticky: an illegal opcode reached ID/EX

Behaviour:
- Control word layout: [10] Jump, [9] BranchNE, [8:5] EX {RegDst, ALUOp1, ALUOp0, ALUSrc}, [4:2] MEM {Branch, MemRead, MemWrite}, [1:0] WB {RegWrite, MemtoReg}.
- All don't-care bits are driven 0; no X is ever output.
- Decode (outDecode, pure combinational):
  - op 0 (R-type) -> 0x182
  - op 35 (lw) -> 0x02B
  - op 43 (sw) -> 0x024
  - op 4 (beq) -> 0x050
  - op 5 (bne) -> 0x250
  - op 8 (addi) -> 0x022
  - op 12/13/10 (andi/ori/slti) -> 0x0E2
  - op 2 (j) -> 0x400
  - any other opcode -> 0x000, and illegal_id = 1
- uses_rt = R-type, beq, bne or sw.
- hazard = outControl[3] (EX MemRead) && outExRt != 0 && (rs == outExRt || (uses_rt && rt == outExRt)).
- FSM states: RUN, STALL; down-counter cnt of width 2.
  - RUN, hazard=0: ID/EX <= {outDecode, rt}; outPcWrite = outIfIdWrite = 1; outStall = 0.
  - RUN, hazard=1: ID/EX control <= 0 (bubble), outExRt <= 0; outPcWrite = outIfIdWrite = 0; outStall = 1.
  - RUN, hazard=1, LOAD_USE_STALL > 1: additionally go to STALL with cnt <= LOAD_USE_STALL-2.
  - STALL: ID/EX <= bubble; PC and IF/ID held; outStall = 1.
  - STALL exit: if cnt == 0, go to RUN; else cnt <= cnt-1.
  - Hazard is not re-evaluated in STALL.
  - Total hold per hazard = exactly LOAD_USE_STALL cycles.
- Flush has priority over everything:
  - ID/EX <= bubble; state <= RUN; counter cleared.
  - outPcWrite = outIfIdWrite = 1 so the redirect target loads.
  - outStall = 0; an in-progress stall is aborted.
- outIllegal:
  - Set on the edge at which an illegal opcode is latched into ID/EX (RUN, no hazard, no flush).
  - Held until reset. A flushed or stalled illegal opcode does not set it.
- Reset (rst = 0 at clk edge), including mid-stall:
  - outControl = 0, outExRt = 0, state = RUN, cnt = 0, outIllegal = 0.
  - Outputs during reset: outPcWrite = 1, outIfIdWrite = 1, outStall = 0.
  - Reset overrides flush and hazard.
- Latency: outDecode 0 cycles; outControl/outExRt 1 cycle after ID.

Test Plan:
- Reset, then lw $5 (0x8C050000) in ID, no flush -> outDecode = 0x02B same cycle; outControl = 0x02B, outExRt = 5 next edge; outPcWrite = 1.
- LOAD_USE_STALL=1: lw $5 then add $6,$5,$7 -> one cycle with outStall = 1, outPcWrite = 0, outControl = 0x000; next cycle outControl = 0x182, no further stall.
- LOAD_USE_STALL=3, same sequence -> exactly 3 bubble cycles with outPcWrite = 0, then add issues. Repeat with lw $0 -> zero stalls.
- LOAD_USE_STALL=3: inFlush asserted in 2nd stall cycle -> same cycle outPcWrite = 1, outStall = 0; next edge outControl = 0x000, state RUN.
- Opcode 63 in ID, no hazard -> outDecode = 0x000; outIllegal = 1 after the edge and remains 1 over 10 legal instructions; with inFlush held during that opcode, outIllegal stays 0.
- rst = 0 during the 2nd stall cycle of LOAD_USE_STALL=3 -> after the edge all outputs at reset values; the next legal instruction issues without stall.
